mfe_img_loader: RTL

Upstream feeder for the median-filter engine (MFE).
- Accepts one 128×128 8-bit grayscale frame as a raster byte stream with a valid/ready handshake.
- Writes the frame into the grayscale image memory that MFE reads through `iaddr`/`idata`.
- Then hands control to MFE with `ready`, waits for MFE's `busy` to rise and fall, and pulses `done`.
- Sits between the host/testbench stream source and MFE, and owns the write port of the image memory.

---
 rtl/mfe_pkg.sv | 23 ++
 rtl/mfe_img_loader_if.sv | 29 ++
 rtl/mfe_raster_cnt.sv | 42 ++++
 rtl/mfe_img_loader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mfe_pkg.sv
// Shared constants and types for the median-filter engine front end:
// frame geometry, address width and the loader state encoding.
package mfe_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int X_W    = 7;
  localparam int Y_W    = 7;
  localparam int NPIX   = IMG_W * IMG_H;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FILL  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/mfe_img_loader_if.sv
// Bundle of the loader's stream, image-memory write and MFE control signals.
// The loader takes the slave view; the host/MFE environment takes the master view.
interface mfe_img_loader_if;
  import mfe_pkg::*;

  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_data;
  logic              img_wen;
  logic              ready;
  logic              busy;
  logic              done;
  logic              frame_err;

  modport master (
    output start, s_valid, s_data, s_last, busy,
    input  s_ready, img_addr, img_data, img_wen, ready, done, frame_err
  );

  modport slave (
    input  start, s_valid, s_data, s_last, busy,
    output s_ready, img_addr, img_data, img_wen, ready, done, frame_err
  );

endinterface

// File: rtl/mfe_raster_cnt.sv
// Raster-order pixel counter: x runs fastest, wraps into y, and the linear
// address is y*IMG_W + x. Saturates on the final pixel of the frame.
module mfe_raster_cnt
  import mfe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] cnt,
  output logic              last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;

  // Column/row registers; increments are dropped at the final pixel so cnt never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (inc && !last) begin
      if (r_x == X_W'(IMG_W - 1)) begin
        r_x <= '0;
        r_y <= r_y + Y_W'(1);
      end else begin
        r_x <= r_x + X_W'(1);
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign cnt  = {r_y, r_x};
  assign last = (cnt == LAST_ADDR);

endmodule

// File: rtl/mfe_img_loader.sv
// Loads one raster frame into the MFE image memory, zero-fills after an early
// s_last, then hands off to MFE via ready/busy and pulses done when it finishes.
module mfe_img_loader
  import mfe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mfe_img_loader_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_FILL  = ST_FILL;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]        r_state;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_img_addr;
  logic [7:0]        r_img_data;
  logic              r_img_wen;
  logic              r_ready;
  logic              r_done;
  logic              r_frame_err;

  logic [2:0]        w_next;
  logic              w_inc;
  logic              w_clr;
  logic              w_wen;
  logic [7:0]        w_wdata;
  logic              w_err_set;
  logic              w_err_clr;
  logic              w_accept;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_last;
  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic              w_unused_xy;

  mfe_raster_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc),
    .clr   (w_clr),
    .x     (w_x),
    .y     (w_y),
    .cnt   (w_cnt),
    .last  (w_last)
  );

  assign w_unused_xy = ^{w_x, w_y};
  assign w_accept    = r_s_ready & bus.s_valid;

  // Next-state, counter control and write-port request for this cycle.
  always_comb begin
    w_next    = r_state;
    w_inc     = 1'b0;
    w_clr     = 1'b0;
    w_wen     = 1'b0;
    w_wdata   = 8'd0;
    w_err_set = 1'b0;
    w_err_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (bus.start) begin
          w_next    = S_LOAD;
          w_err_clr = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_wen   = 1'b1;
          w_wdata = bus.s_data;
          if (w_last) begin
            w_next    = S_START;
            w_err_set = ~bus.s_last;
          end else begin
            w_inc = 1'b1;
            if (bus.s_last) begin
              w_err_set = 1'b1;
              w_next    = S_FILL;
            end else begin
              w_next = S_LOAD;
            end
          end
        end else begin
          w_next = S_LOAD;
        end
      end
      S_FILL: begin
        w_wen = 1'b1;
        if (w_last) begin
          w_next = S_START;
        end else begin
          w_inc  = 1'b1;
          w_next = S_FILL;
        end
      end
      S_START: begin
        if (bus.busy) w_next = S_RUN;
        else          w_next = S_START;
      end
      S_RUN: begin
        if (!bus.busy) w_next = S_DONE;
        else           w_next = S_RUN;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State and registered outputs; s_ready decodes the next state so it drops right after the final beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_s_ready   <= 1'b0;
      r_img_addr  <= '0;
      r_img_data  <= 8'd0;
      r_img_wen   <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_s_ready <= (w_next == S_LOAD);
      r_img_wen <= w_wen;
      if (w_wen) begin
        r_img_addr <= w_cnt;
        r_img_data <= w_wdata;
      end
      r_ready <= (r_state == S_START) && !bus.busy;
      r_done  <= (w_next == S_DONE);
      if (w_err_clr) begin
        r_frame_err <= 1'b0;
      end else if (w_err_set) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.img_addr  = r_img_addr;
  assign bus.img_data  = r_img_data;
  assign bus.img_wen   = r_img_wen;
  assign bus.ready     = r_ready;
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;

endmodule
